// File: rtl/core_wbu.sv
`default_nettype none
// ---------------------------------------------------------------------------
// core_wbu : writeback arbiter for LSU/EXU results onto GPR/CSR write ports
// Revision : 1.0
// ---------------------------------------------------------------------------
module core_wbu #(
    parameter int DATA_W     = 32,
    parameter int REG_W      = 5,
    parameter int CSR_W      = 12,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              exu_vld_i,
    output logic              exu_ready_o,
    input  logic [REG_W-1:0]  exu_rd_i,
    input  logic              exu_rd_we_i,
    input  logic [DATA_W-1:0] exu_rd_data_i,
    input  logic [CSR_W-1:0]  exu_csr_addr_i,
    input  logic              exu_csr_we_i,
    input  logic [DATA_W-1:0] exu_csr_data_i,
    input  logic              lsu_vld_i,
    input  logic [REG_W-1:0]  lsu_rd_i,
    input  logic [DATA_W-1:0] lsu_data_i,
    output logic [REG_W-1:0]  reg_waddr_o,
    output logic              reg_waddr_vld_o,
    output logic [DATA_W-1:0] reg_wdata_o,
    output logic [CSR_W-1:0]  csr_waddr_o,
    output logic              csr_waddr_vld_o,
    output logic [DATA_W-1:0] csr_wdata_o,
    output logic [31:0]       busy_o,
    output logic              retire_o,
    output logic [63:0]       minstret_o
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [REG_W-1:0]      r_f_rd       [FIFO_DEPTH];
    logic                  r_f_rd_we    [FIFO_DEPTH];
    logic [DATA_W-1:0]     r_f_rd_data  [FIFO_DEPTH];
    logic [CSR_W-1:0]      r_f_csr_addr [FIFO_DEPTH];
    logic                  r_f_csr_we   [FIFO_DEPTH];
    logic [DATA_W-1:0]     r_f_csr_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] r_f_vld;
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;

    logic [REG_W-1:0]      r_reg_waddr;
    logic                  r_reg_vld;
    logic [DATA_W-1:0]     r_reg_wdata;
    logic [CSR_W-1:0]      r_csr_waddr;
    logic                  r_csr_vld;
    logic [DATA_W-1:0]     r_csr_wdata;
    logic                  r_retire;
    logic [63:0]           r_minstret;

    logic                  w_hs;
    logic                  w_empty;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_bypass;
    logic [REG_W-1:0]      w_reg_waddr;
    logic                  w_reg_vld;
    logic [DATA_W-1:0]     w_reg_wdata;
    logic [CSR_W-1:0]      w_csr_waddr;
    logic                  w_csr_vld;
    logic [DATA_W-1:0]     w_csr_wdata;
    logic                  w_retire;
    logic [31:0]           w_busy;

    // Ready comes from the registered count only, so a same-cycle pop never frees a slot early.
    assign exu_ready_o = !rst_i && (r_count < CNT_W'(FIFO_DEPTH));
    assign w_hs        = exu_vld_i && exu_ready_o;
    assign w_empty     = (r_count == '0);
    assign w_pop       = !lsu_vld_i && !w_empty;
    assign w_push      = w_hs && (lsu_vld_i || !w_empty);
    assign w_bypass    = w_hs && !lsu_vld_i && w_empty;

    always_comb begin
        w_reg_waddr = r_reg_waddr;
        w_reg_wdata = r_reg_wdata;
        w_csr_waddr = r_csr_waddr;
        w_csr_wdata = r_csr_wdata;
        w_reg_vld   = 1'b0;
        w_csr_vld   = 1'b0;
        w_retire    = 1'b0;
        if (lsu_vld_i) begin
            w_reg_waddr = lsu_rd_i;
            w_reg_wdata = lsu_data_i;
            w_reg_vld   = (lsu_rd_i != '0);
            w_retire    = 1'b1;
        end else if (w_pop) begin
            w_reg_waddr = r_f_rd[r_rd_ptr];
            w_reg_wdata = r_f_rd_data[r_rd_ptr];
            w_reg_vld   = r_f_rd_we[r_rd_ptr] && (r_f_rd[r_rd_ptr] != '0);
            w_csr_waddr = r_f_csr_addr[r_rd_ptr];
            w_csr_wdata = r_f_csr_data[r_rd_ptr];
            w_csr_vld   = r_f_csr_we[r_rd_ptr];
            w_retire    = 1'b1;
        end else if (w_bypass) begin
            w_reg_waddr = exu_rd_i;
            w_reg_wdata = exu_rd_data_i;
            w_reg_vld   = exu_rd_we_i && (exu_rd_i != '0);
            w_csr_waddr = exu_csr_addr_i;
            w_csr_wdata = exu_csr_data_i;
            w_csr_vld   = exu_csr_we_i;
            w_retire    = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_f_vld     <= '0;
            r_reg_waddr <= '0;
            r_reg_vld   <= 1'b0;
            r_reg_wdata <= '0;
            r_csr_waddr <= '0;
            r_csr_vld   <= 1'b0;
            r_csr_wdata <= '0;
            r_retire    <= 1'b0;
            r_minstret  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr          <= r_wr_ptr + PTR_W'(1);
                r_f_vld[r_wr_ptr] <= 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr          <= r_rd_ptr + PTR_W'(1);
                r_f_vld[r_rd_ptr] <= 1'b0;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
            r_reg_waddr <= w_reg_waddr;
            r_reg_vld   <= w_reg_vld;
            r_reg_wdata <= w_reg_wdata;
            r_csr_waddr <= w_csr_waddr;
            r_csr_vld   <= w_csr_vld;
            r_csr_wdata <= w_csr_wdata;
            r_retire    <= w_retire;
            r_minstret  <= r_minstret + 64'(w_retire);
        end
    end

    // Payload storage needs no reset; r_f_vld qualifies every slot.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_f_rd[r_wr_ptr]       <= exu_rd_i;
            r_f_rd_we[r_wr_ptr]    <= exu_rd_we_i;
            r_f_rd_data[r_wr_ptr]  <= exu_rd_data_i;
            r_f_csr_addr[r_wr_ptr] <= exu_csr_addr_i;
            r_f_csr_we[r_wr_ptr]   <= exu_csr_we_i;
            r_f_csr_data[r_wr_ptr] <= exu_csr_data_i;
        end
    end

    always_comb begin
        w_busy = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (r_f_vld[i] && r_f_rd_we[i] && (r_f_rd[i] != '0)) begin
                w_busy[r_f_rd[i]] = 1'b1;
            end
        end
        if (r_reg_vld) begin
            w_busy[r_reg_waddr] = 1'b1;
        end
        w_busy[0] = 1'b0;
    end

    assign busy_o          = w_busy;
    assign reg_waddr_o     = r_reg_waddr;
    assign reg_waddr_vld_o = r_reg_vld;
    assign reg_wdata_o     = r_reg_wdata;
    assign csr_waddr_o     = r_csr_waddr;
    assign csr_waddr_vld_o = r_csr_vld;
    assign csr_wdata_o     = r_csr_wdata;
    assign retire_o        = r_retire;
    assign minstret_o      = r_minstret;

endmodule
`default_nettype wire
